// File: rtl/rv32i_types.sv
// rv32i_types: shared adaptor state encoding and beat-count helper
package rv32i_types;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adaptor_state_t;

    function automatic int beats_of(input int lw, input int bw);
        return lw / bw;
    endfunction

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor: turns one cache-line read/write into a fixed-length burst of narrower memory beats
module cacheline_burst_adaptor
    import rv32i_types::*;
#(
    parameter int line_width  = 256,
    parameter int burst_width = 64,
    parameter int s_offset    = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            pmem_address,
    input  logic                   pmem_read,
    input  logic                   pmem_write,
    input  logic [line_width-1:0]  pmem_wdata,
    output logic [line_width-1:0]  pmem_rdata,
    output logic                   pmem_resp,
    output logic [31:0]            burst_address,
    output logic                   burst_read,
    output logic                   burst_write,
    output logic [burst_width-1:0] burst_wdata,
    input  logic [burst_width-1:0] burst_rdata,
    input  logic                   burst_resp
);

    localparam int BEATS = beats_of(line_width, burst_width);
    localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;

    adaptor_state_t        state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [line_width-1:0] buf_q, buf_d;
    logic [line_width-1:0] rdata_q, rdata_d;
    logic [31:0]           addr_q, addr_d;
    logic                  last;

    assign last          = cnt_q == CW'(BEATS - 1);
    assign burst_read    = state_q == READ;
    assign burst_write   = state_q == WRITE;
    assign pmem_resp     = state_q == DONE;
    assign burst_address = addr_q;
    assign burst_wdata   = buf_q[cnt_q*burst_width +: burst_width];
    assign pmem_rdata    = rdata_q;

    // Next-state: accept a request in IDLE, move one beat per burst_resp, publish the read line on the last beat
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: if (pmem_read || pmem_write) begin
                addr_d  = pmem_address & ~((32'd1 << s_offset) - 32'd1);
                state_d = pmem_read ? READ : WRITE;
                buf_d   = pmem_read ? buf_q : pmem_wdata;
            end
            READ: if (burst_resp) begin
                buf_d[cnt_q*burst_width +: burst_width] = burst_rdata;
                cnt_d   = last ? '0 : cnt_q + CW'(1);
                state_d = last ? DONE : READ;
                rdata_d = last ? buf_d : rdata_q;
            end
            WRITE: if (burst_resp) begin
                cnt_d   = last ? '0 : cnt_q + CW'(1);
                state_d = last ? DONE : WRITE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any burst at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// tb_cacheline_burst_adaptor: table-driven, hand-written and randomized checks against a line-level memory model
module tb_cacheline_burst_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  burst_address;
    logic         burst_read;
    logic         burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    int checks = 0;
    int failures = 0;
    logic [255:0] exp_rdata = '0;
    logic [31:0]  last_addr = '0;

    typedef struct {
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wd;
        logic [255:0] rl;
        int           stall_at;
        int           stall_len;
        logic [31:0]  exp_addr;
        int           exp_lat;
    } vec_t;

    vec_t tbl[5];

    cacheline_burst_adaptor dut (
        .clk(clk), .rst(rst),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .burst_address(burst_address), .burst_read(burst_read), .burst_write(burst_write),
        .burst_wdata(burst_wdata), .burst_rdata(burst_rdata), .burst_resp(burst_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    // One line transaction seen from both sides; memory acks per the stall pattern and optional random gaps
    task automatic run(input vec_t v, input bit rnd_gaps, input bit hold_wr, input string tag);
        int beats, cyc, stalled, gaps;
        bit s, g, is_rd;
        beats = 0; cyc = 0; stalled = 0; gaps = 0;
        is_rd = v.rd;
        pmem_read = v.rd; pmem_write = v.wr; pmem_address = v.addr; pmem_wdata = v.wd;
        burst_resp = 1'b0;
        step();
        while (!pmem_resp && cyc < 60) begin
            chk({tag, " burst_read"}, 256'(burst_read), 256'(is_rd));
            chk({tag, " burst_write"}, 256'(burst_write), 256'(!is_rd));
            chk({tag, " burst_address"}, 256'(burst_address), 256'(v.exp_addr));
            chk({tag, " rdata_held"}, pmem_rdata, exp_rdata);
            if (!is_rd) chk({tag, " burst_wdata"}, 256'(burst_wdata), 256'(v.wd[beats*64 +: 64]));
            pmem_address = $urandom;
            pmem_wdata = rnd_line();
            s = (beats == v.stall_at) && (stalled < v.stall_len);
            g = rnd_gaps && ($urandom_range(0, 2) == 0);
            if (s) stalled++;
            burst_resp = !(s || g);
            if (!burst_resp) gaps++;
            burst_rdata = burst_resp ? v.rl[beats*64 +: 64] : {$urandom, $urandom};
            step();
            if (burst_resp) beats++;
            cyc++;
        end
        burst_resp = 1'b0;
        chk({tag, " resp_seen"}, 256'(pmem_resp), 256'(1));
        chk({tag, " latency"}, 256'(cyc + 1), 256'(v.exp_lat != 0 ? v.exp_lat : 5 + gaps));
        chk({tag, " beats"}, 256'(beats), 256'(4));
        if (is_rd) exp_rdata = v.rl;
        chk({tag, " pmem_rdata"}, pmem_rdata, exp_rdata);
        chk({tag, " burst_idle_in_done"}, 256'({burst_read, burst_write}), 256'(0));
        last_addr = v.exp_addr;
        step();
        chk({tag, " resp_one_cycle"}, 256'(pmem_resp), 256'(0));
        chk({tag, " idle_after_done"}, 256'({burst_read, burst_write}), 256'(0));
        pmem_read = 1'b0;
        pmem_write = hold_wr;
    endtask

    initial begin
        vec_t v;
        rst = 1'b0;
        pmem_address = '0; pmem_read = 1'b0; pmem_write = 1'b0; pmem_wdata = '0;
        burst_rdata = '0; burst_resp = 1'b0;
        tbl[0] = '{1, 0, 32'h0000_1234, '0,
                   {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, -1, 0, 32'h0000_1220, 5};
        tbl[1] = '{1, 0, 32'h0000_1234, '0,
                   {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 2, 2, 32'h0000_1220, 7};
        tbl[2] = '{0, 1, 32'h8000_0040,
                   256'h0123456789ABCDEF_1122334455667788_99AABBCCDDEEFF00_0123456789ABCDEF,
                   '0, -1, 0, 32'h8000_0040, 5};
        tbl[3] = '{1, 0, 32'hDEAD_BEEF, '0,
                   256'hCAFEF00D_00000001_FEEDFACE_00000002_BAADC0DE_00000003_8BADF00D_00000004,
                   0, 3, 32'hDEAD_BEE0, 8};
        tbl[4] = '{0, 1, 32'h0000_001F,
                   256'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0_13579BDF_2468ACE0,
                   '0, 3, 1, 32'h0000_0000, 6};

        repeat (2) @(posedge clk);
        #1;
        chk("reset pmem_resp", 256'(pmem_resp), 256'(0));
        chk("reset burst_rw", 256'({burst_read, burst_write}), 256'(0));
        chk("reset burst_address", 256'(burst_address), 256'(0));
        chk("reset pmem_rdata", pmem_rdata, 256'(0));
        chk("reset burst_wdata", 256'(burst_wdata), 256'(0));
        rst = 1'b1;
        step();

        for (int i = 0; i < 5; i++) run(tbl[i], 1'b0, 1'b0, $sformatf("tbl%0d", i));

        v = '{1, 1, 32'h0000_2468, 256'hFACE_0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE,
              rnd_line(), -1, 0, 32'h0000_2460, 5};
        run(v, 1'b0, 1'b1, "sim_read");
        v.rd = 1'b0;
        run(v, 1'b0, 1'b0, "sim_write");

        for (int i = 0; i < 3; i++) begin
            burst_resp = 1'b1;
            burst_rdata = {$urandom, $urandom};
            step();
            chk("spurious rw", 256'({burst_read, burst_write, pmem_resp}), 256'(0));
            chk("spurious rdata", pmem_rdata, exp_rdata);
            chk("spurious addr", 256'(burst_address), 256'(last_addr));
        end
        burst_resp = 1'b0;
        v = '{1, 0, 32'h0000_4000, '0, rnd_line(), -1, 0, 32'h0000_4000, 5};
        run(v, 1'b0, 1'b0, "after_spurious");

        pmem_read = 1'b1;
        pmem_address = 32'h0000_5555;
        step();
        for (int i = 0; i < 2; i++) begin
            burst_resp = 1'b1;
            burst_rdata = {$urandom, $urandom};
            step();
        end
        burst_resp = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("abort burst_read", 256'(burst_read), 256'(0));
        chk("abort pmem_rdata", pmem_rdata, 256'(0));
        chk("abort burst_address", 256'(burst_address), 256'(0));
        chk("abort pmem_resp", 256'(pmem_resp), 256'(0));
        pmem_read = 1'b0;
        exp_rdata = '0;
        last_addr = '0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_abort quiet", 256'({burst_read, burst_write, pmem_resp}), 256'(0));
        end
        v = '{1, 0, 32'h0000_5555, '0, rnd_line(), -1, 0, 32'h0000_5540, 5};
        run(v, 1'b0, 1'b0, "post_abort_read");

        for (int i = 0; i < 30; i++) begin
            v.rd = 1'($urandom_range(0, 1));
            v.wr = !v.rd || 1'($urandom_range(0, 1));
            v.addr = $urandom;
            v.wd = rnd_line();
            v.rl = rnd_line();
            v.stall_at = -1;
            v.stall_len = 0;
            v.exp_addr = v.addr & 32'hFFFF_FFE0;
            v.exp_lat = 0;
            run(v, 1'b1, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
- Responder for the cache's physical-memory line port. It accepts one full-line read or write per request: pmem_address, pmem_wdata and pmem_read/pmem_write in, pmem_rdata and pmem_resp out.
- On the memory side it acts as initiator. It converts each line into a fixed-length burst of narrower beats for the DRAM/memory model.
- It sits between the cache (or arbiter) and main memory. It has one outstanding transaction at a time.

Parameters:
- line_width, 256, cache line width in bits (matches the cache datapath width).
- burst_width, 64, memory beat width in bits; must divide line_width.
- s_offset, 5, line-offset bits; log2(line_width/8).

Ports:
- clk  input  1  single clock; all state changes on posedge.
- rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
- pmem_address  input  32  line address from the cache; low s_offset bits ignored.
- pmem_read  input  1  line read request; held until pmem_resp.
- pmem_write  input  1  line write request; held until pmem_resp.
- pmem_wdata  input  line_width  write line; sampled at request acceptance only.
- pmem_rdata  output  line_width  read line; valid when pmem_resp=1, then held.
- pmem_resp  output  1  one-cycle completion pulse.
- burst_address  output  32  line-aligned address: {pmem_address[31:s_offset], s_offset'b0}.
- burst_read  output  1  memory read burst request.
- burst_write  output  1  memory write burst request.
- burst_wdata  output  burst_width  current write beat.
- burst_rdata  input  burst_width  read beat from memory.
- burst_resp  input  1  memory beat acknowledge; one beat per cycle it is high.

Behaviour:
- BEATS = line_width/burst_width (default 4). Beat counter is $clog2(BEATS) bits plus a last-beat flag.
- Reset (rst=0, async): state IDLE, counter 0, line buffer 0, burst_address 0, and all other outputs 0. pmem_rdata is also 0.
- States: IDLE, READ, WRITE, DONE. All outputs are registered or Moore-decoded from state; there is no combinational input-to-output path.
- IDLE:
  - pmem_read=1: latch the aligned address, go to READ.
  - Else pmem_write=1: latch the address and pmem_wdata, go to WRITE.
  - Both high: read wins; the write is serviced after it if still held.
- READ:
  - burst_read=1 and burst_address stable.
  - Each edge with burst_resp=1 stores burst_rdata into beat slot counter. Beat k occupies bits [k*burst_width +: burst_width], so beat 0 is the LSBs.
  - The counter then increments.
  - Gaps (burst_resp=0) stall without losing state.
  - The edge accepting beat BEATS-1 moves to DONE; burst_read is 0 in DONE.
- WRITE:
  - burst_write=1 and burst_wdata = buffered slot counter.
  - Each burst_resp=1 advances the counter. After beat BEATS-1 is acknowledged, go to DONE.
- DONE: pmem_resp=1 for exactly one cycle, then IDLE.
  - After a read, pmem_rdata holds the assembled line until the next read completes.
  - After a write, pmem_rdata is unchanged.
- Minimum latency (burst_resp high every cycle): request seen at edge 0, burst_* high in cycles 1–4, pmem_resp in cycle 5. The next request can be accepted at edge 6.
- burst_resp while in IDLE or DONE is ignored, with no state change.
- The counter wraps to 0 on entering DONE.
- pmem_address or pmem_wdata changing mid-transaction has no effect; both are latched at acceptance.
- Reset asserted mid-burst aborts the transaction immediately:
  - burst_read and burst_write drop asynchronously; no pmem_resp is issued.
  - After reset releases, the FSM is in IDLE.
- The cache holds its request until it sees pmem_resp and drops it the following cycle. The block therefore sees the request low in IDLE after DONE and does not restart.

Decomposition:
- Shared package (rv32i_types): adaptor state enum typedef (IDLE/READ/WRITE/DONE) and a BEATS-derivation localparam helper.
- Single module; no sub-module needed. The line buffer is one line_width register shared between read assembly and write staging.

Test Plan:
- Back-to-back read: addr 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles.
  - burst_address = 0x0000_1220.
  - pmem_resp 5 cycles after the request.
  - pmem_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Stalled read: same as above with burst_resp low for 2 cycles between beats 1 and 2.
  - Identical pmem_rdata; pmem_resp delayed by 2 cycles; burst_read stays high throughout.
- Write: addr 0x8000_0040, wdata = 256'h0123...CDEF.
  - burst_wdata steps through 64-bit slices LSB-first, one per burst_resp.
  - burst_write drops and pmem_resp pulses once after the 4th ack.
- Simultaneous pmem_read and pmem_write in IDLE: read burst issued first. With pmem_write held, a write burst follows after the read's DONE.
- Reset mid-read: rst=0 after 2 beats.
  - burst_read=0 and pmem_rdata=0 immediately.
  - No pmem_resp.
  - A subsequent full read completes normally with a fresh counter.
- Spurious burst_resp=1 in IDLE for 3 cycles: no output change. The next read still collects exactly 4 beats.
